// File: rtl/apb_sched_pkg.sv
// Shared types and helpers for the APB request scheduler.
// SEL_W/REQ_W describe the default configuration; instances with other
// COMP/NREQ values derive their own widths locally.
package apb_sched_pkg;

  localparam int unsigned COMP_DEFAULT = 4;
  localparam int unsigned NREQ_DEFAULT = 3;
  localparam int unsigned SEL_W        = $clog2(COMP_DEFAULT);
  localparam int unsigned REQ_W        = $clog2(NREQ_DEFAULT);

  // Upper bound on completer count supported by the decode helper.
  localparam int unsigned MAX_COMP = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_e;

  typedef struct packed {
    logic                err;
    logic [MAX_COMP-1:0] sel;
  } decode_t;

  // Completer index -> {err, one-hot select}; indices past the last completer
  // produce an error and an all-zero select.
  function automatic decode_t decode_sel(input int unsigned index, input int unsigned comp);
    decode_t d;
    d.err = 1'b0;
    d.sel = '0;
    if (index < comp) begin
      d.sel = MAX_COMP'(1) << index;
    end else begin
      d.err = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/apb_req_scheduler_if.sv
// Requester-side handshake and bridge M-side signals of the APB scheduler.
// master: the scheduler itself; slave: the requesters plus the bridge.
interface apb_req_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned COMP       = 4,
  parameter int unsigned NREQ       = 3
);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_write;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*DATA_WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]      rsp_rdata;
  logic                       rsp_err;

  logic                       MTRANS;
  logic                       MWRITE;
  logic [COMP-1:0]            MSELx;
  logic [ADDR_WIDTH-1:0]      MADDR;
  logic [DATA_WIDTH-1:0]      MWDATA;
  logic                       PENABLE;
  logic                       PREADY;
  logic [DATA_WIDTH-1:0]      MRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PENABLE, PREADY, MRDATA,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, MTRANS, MWRITE, MSELx, MADDR, MWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PENABLE, PREADY, MRDATA,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, MTRANS, MWRITE, MSELx, MADDR, MWDATA
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Requester arbiter: one-hot grant plus binary index of the winner.
// Default: round-robin, search starts one past ptr and wraps at NREQ.
// APB_SCHED_FIXED_PRIO_EN: fixed priority, requester 0 highest, no ptr port.
module apb_rr_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned REQ_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
`ifdef APB_SCHED_FIXED_PRIO_EN
`else
  input  logic [REQ_W-1:0] ptr,
`endif
  output logic [NREQ-1:0]  grant,
  output logic [REQ_W-1:0] idx,
  output logic             any
);

`ifdef APB_SCHED_FIXED_PRIO_EN

  // Walk from highest index down so the lowest requesting index wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (|(req & (NREQ'(1) << i))) begin
        any   = 1'b1;
        idx   = REQ_W'(i);
        grant = NREQ'(1) << i;
      end
    end
  end

`else

  logic [REQ_W-1:0] cand;

  // First requester found at ptr+1, ptr+2, ... (mod NREQ) wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = REQ_W'((32'(ptr) + off) % NREQ);
      if (!any && |(req & (NREQ'(1) << cand))) begin
        any   = 1'b1;
        idx   = cand;
        grant = NREQ'(1) << cand;
      end
    end
  end

`endif

endmodule

// File: rtl/apb_req_scheduler.sv
// Shares one APB bridge between NREQ requesters, one transaction at a time.
// Arbitrates, decodes the completer select from the top address bits, drives
// the bridge M-side from holding registers and returns the response.
// Build option: APB_SCHED_FIXED_PRIO_EN selects fixed priority (requester 0
// highest) instead of round-robin and drops the round-robin pointer.
module apb_req_scheduler
  import apb_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned COMP       = COMP_DEFAULT,
  parameter int unsigned NREQ       = NREQ_DEFAULT
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_req_scheduler_if.master bus
);

  localparam int unsigned SelW = $clog2(COMP);
  localparam int unsigned ReqW = $clog2(NREQ);

  sched_state_e state_q, state_d;

  logic [NREQ-1:0]       win_grant;
  logic [ReqW-1:0]       win_idx;
  logic                  win_any;
  logic                  accept;
  logic                  win_write;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  decode_t               dec;
  logic                  unused_dec;

  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ReqW-1:0]       idx_q;
  logic [COMP-1:0]       sel_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

`ifdef APB_SCHED_FIXED_PRIO_EN
`else
  logic [ReqW-1:0]       rr_ptr_q;
`endif

  apb_rr_arbiter #(
    .NREQ  (NREQ),
    .REQ_W (ReqW)
  ) u_arb (
    .req   (bus.req_valid),
`ifdef APB_SCHED_FIXED_PRIO_EN
`else
    .ptr   (rr_ptr_q),
`endif
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign win_write = |(bus.req_write & win_grant);
  assign win_addr  = bus.req_addr[32'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata = bus.req_wdata[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
  assign dec       = decode_sel(32'(win_addr[ADDR_WIDTH-1 -: SelW]), COMP);
  // Select bits above COMP are always zero for in-range indices.
  assign unused_dec = ^dec.sel;

  // State register; reset abandons any transaction without a response.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; accepts only in IDLE, decode errors skip the bus entirely.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          accept  = 1'b1;
          state_d = dec.err ? RESP : ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.PENABLE && bus.PREADY) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef APB_SCHED_FIXED_PRIO_EN
`else
  // Round-robin pointer follows the last accepted requester.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rr_ptr_q <= ReqW'(NREQ - 1);
    end else if (accept) begin
      rr_ptr_q <= win_idx;
    end
  end
`endif

  // Holding registers: request captured on accept, read data on completion.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      write_q <= win_write;
      addr_q  <= win_addr;
      wdata_q <= win_wdata;
      idx_q   <= win_idx;
      sel_q   <= dec.sel[COMP-1:0];
      err_q   <= dec.err;
      rdata_q <= '0;
    end else if (state_q == WAIT && bus.PENABLE && bus.PREADY) begin
      rdata_q <= write_q ? '0 : bus.MRDATA;
    end
  end

  // M-side comes straight from the holding registers so it stays stable
  // for the whole bridge transfer.
  always_comb begin
    bus.MTRANS    = (state_q == ISSUE);
    bus.MWRITE    = write_q;
    bus.MSELx     = sel_q;
    bus.MADDR     = addr_q;
    bus.MWDATA    = wdata_q;
    bus.req_ready = accept ? win_grant : '0;
    bus.rsp_valid = (state_q == RESP) ? (NREQ'(1) << idx_q) : '0;
    bus.rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    bus.rsp_err   = (state_q == RESP) && err_q;
  end

endmodule

// File: tb/tb_apb_req_scheduler.sv
// Directed bench for apb_req_scheduler: a COMP=4 instance with a small
// bridge model for the bus tests, and a COMP=3 instance for decode errors.
module tb_apb_req_scheduler;
  import apb_sched_pkg::*;

  localparam int unsigned CompA = 1 << SEL_W;

  logic PCLK;
  logic PRESET;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  apb_req_scheduler_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .COMP(CompA), .NREQ(3)) bus_a ();
  apb_req_scheduler_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .COMP(3), .NREQ(3)) bus_b ();

  apb_req_scheduler #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .COMP(CompA), .NREQ(3)) dut_a (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus_a.master)
  );

  apb_req_scheduler #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .COMP(3), .NREQ(3)) dut_b (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus_b.master)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Bridge model: IDLE -> SETUP on MTRANS, SETUP -> ACCESS, ACCESS holds until PREADY.
  typedef enum logic [1:0] {BrIdle, BrSetup, BrAccess} br_e;
  br_e br_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      br_q <= BrIdle;
    end else begin
      case (br_q)
        BrIdle:   if (bus_a.MTRANS) br_q <= BrSetup;
        BrSetup:  br_q <= BrAccess;
        BrAccess: if (bus_a.PREADY) br_q <= bus_a.MTRANS ? BrSetup : BrIdle;
        default:  br_q <= BrIdle;
      endcase
    end
  end

  assign bus_a.PENABLE = (br_q == BrAccess);
  assign bus_b.PENABLE = 1'b0;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int               gap;
    logic [2:0]       exp_grant;
    logic [REQ_W-1:0] exp_idx;

    PRESET          = 1'b1;
    bus_a.req_valid = '0;
    bus_a.req_write = '0;
    bus_a.req_addr  = '0;
    bus_a.req_wdata = '0;
    bus_a.PREADY    = 1'b1;
    bus_a.MRDATA    = '0;
    bus_b.req_valid = '0;
    bus_b.req_write = '0;
    bus_b.req_addr  = '0;
    bus_b.req_wdata = '0;
    bus_b.PREADY    = 1'b1;
    bus_b.MRDATA    = 32'hFFFF_FFFF;

    // Reset state
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_mtrans", bus_a.MTRANS, 1'b0);
    check("rst_msel", bus_a.MSELx, 4'b0000);
    check("rst_maddr", bus_a.MADDR, 32'h0);
    check("rst_rsp_valid", bus_a.rsp_valid, 3'b000);
    check("rst_req_ready", bus_a.req_ready, 3'b000);
    PRESET = 1'b0;
    tick();

    // Single read through requester 0
    bus_a.req_valid          = 3'b001;
    bus_a.req_write          = 3'b000;
    bus_a.req_addr[0 +: 32]  = 32'h4000_0010;
    bus_a.PREADY             = 1'b1;
    bus_a.MRDATA             = 32'hA5A5_0001;
    #1;
    check("t1_req_ready", bus_a.req_ready, 3'b001);
    tick();  // T+1
    bus_a.req_valid = 3'b000;
    check("t1_mtrans", bus_a.MTRANS, 1'b1);
    check("t1_msel", bus_a.MSELx, 4'b0010);
    check("t1_maddr", bus_a.MADDR, 32'h4000_0010);
    tick();  // T+2
    check("t1_mtrans_off", bus_a.MTRANS, 1'b0);
    tick();  // T+3
    check("t1_no_early_rsp", bus_a.rsp_valid, 3'b000);
    tick();  // T+4
    check("t1_rsp_valid", bus_a.rsp_valid, 3'b001);
    check("t1_rsp_rdata", bus_a.rsp_rdata, 32'hA5A5_0001);
    check("t1_rsp_err", bus_a.rsp_err, 1'b0);
    tick();  // T+5
    check("t1_rsp_pulse", bus_a.rsp_valid, 3'b000);

    // Write through requester 1 with three PREADY-low access cycles
    bus_a.req_valid          = 3'b010;
    bus_a.req_write          = 3'b010;
    bus_a.req_addr[32 +: 32] = 32'hC000_0000;
    bus_a.req_wdata[32 +: 32] = 32'h0000_1234;
    bus_a.PREADY             = 1'b0;
    bus_a.MRDATA             = 32'hDEAD_BEEF;
    #1;
    check("t2_req_ready", bus_a.req_ready, 3'b010);
    tick();  // T+1
    bus_a.req_valid = 3'b000;
    check("t2_mtrans", bus_a.MTRANS, 1'b1);
    check("t2_msel", bus_a.MSELx, 4'b1000);
    check("t2_mwrite", bus_a.MWRITE, 1'b1);
    check("t2_mwdata", bus_a.MWDATA, 32'h0000_1234);
    repeat (3) tick();  // T+4
    check("t2_wait_rsp", bus_a.rsp_valid, 3'b000);
    check("t2_wait_mwdata", bus_a.MWDATA, 32'h0000_1234);
    check("t2_wait_msel", bus_a.MSELx, 4'b1000);
    repeat (2) tick();  // T+6
    bus_a.PREADY = 1'b1;
    check("t2_still_wait", bus_a.rsp_valid, 3'b000);
    tick();  // T+7
    check("t2_rsp_valid", bus_a.rsp_valid, 3'b010);
    check("t2_rsp_rdata", bus_a.rsp_rdata, 32'h0);
    tick();  // T+8

    // Late arrival: requester 2 raises during requester 0's WAIT
    bus_a.req_valid          = 3'b001;
    bus_a.req_write          = 3'b000;
    bus_a.req_addr[0 +: 32]  = 32'h0000_0100;
    bus_a.MRDATA             = 32'h5555_AAAA;
    #1;
    check("t6_req0_ready", bus_a.req_ready, 3'b001);
    tick();  // T+1
    bus_a.req_valid = 3'b000;
    tick();  // T+2
    bus_a.req_valid          = 3'b100;
    bus_a.req_addr[64 +: 32] = 32'h8000_0020;
    #1;
    check("t6_no_ready_wait", bus_a.req_ready, 3'b000);
    tick();  // T+3
    check("t6_no_ready_access", bus_a.req_ready, 3'b000);
    tick();  // T+4
    check("t6_rsp0_valid", bus_a.rsp_valid, 3'b001);
    check("t6_rsp0_rdata", bus_a.rsp_rdata, 32'h5555_AAAA);
    check("t6_no_ready_resp", bus_a.req_ready, 3'b000);
    tick();  // T+5
    check("t6_req2_ready", bus_a.req_ready, 3'b100);
    tick();  // U+1
    bus_a.req_valid = 3'b000;
    bus_a.MRDATA    = 32'h0BAD_F00D;
    check("t6_msel2", bus_a.MSELx, 4'b0100);
    repeat (3) tick();  // U+4
    check("t6_rsp2_valid", bus_a.rsp_valid, 3'b100);
    check("t6_rsp2_rdata", bus_a.rsp_rdata, 32'h0BAD_F00D);
    tick();

    // Reset while waiting on PREADY
    bus_a.req_valid          = 3'b010;
    bus_a.req_write          = 3'b000;
    bus_a.req_addr[32 +: 32] = 32'h4000_0040;
    bus_a.PREADY             = 1'b0;
    #1;
    check("t5_req_ready", bus_a.req_ready, 3'b010);
    tick();  // T+1
    bus_a.req_valid = 3'b000;
    repeat (2) tick();  // T+3
    check("t5_pre_msel", bus_a.MSELx, 4'b0010);
    PRESET = 1'b1;
    #1;
    check("t5_rst_mtrans", bus_a.MTRANS, 1'b0);
    check("t5_rst_msel", bus_a.MSELx, 4'b0000);
    check("t5_rst_maddr", bus_a.MADDR, 32'h0);
    check("t5_rst_rsp", bus_a.rsp_valid, 3'b000);
    tick();
    tick();
    PRESET       = 1'b0;
    bus_a.PREADY = 1'b1;
    tick();
    check("t5_no_rsp_after", bus_a.rsp_valid, 3'b000);
    bus_a.req_valid           = 3'b100;
    bus_a.req_write           = 3'b100;
    bus_a.req_addr[64 +: 32]  = 32'h4000_0000;
    bus_a.req_wdata[64 +: 32] = 32'h0000_0077;
    #1;
    check("t5_new_ready", bus_a.req_ready, 3'b100);
    tick();
    bus_a.req_valid = 3'b000;
    repeat (3) tick();
    check("t5_new_rsp", bus_a.rsp_valid, 3'b100);
    tick();

    // Arbitration with all three requesters held
    bus_a.req_valid           = 3'b111;
    bus_a.req_write           = 3'b000;
    bus_a.req_addr[0 +: 32]   = 32'h0000_0000;
    bus_a.req_addr[32 +: 32]  = 32'h4000_0000;
    bus_a.req_addr[64 +: 32]  = 32'h8000_0000;
    #1;
    exp_grant = 3'b001;
    for (int k = 0; k < 6; k++) begin
`ifdef APB_SCHED_FIXED_PRIO_EN
      exp_idx = '0;
`else
      exp_idx = REQ_W'(k % 3);
`endif
      exp_grant = 3'b001 << exp_idx;
      check($sformatf("t3_grant%0d", k), bus_a.req_ready, exp_grant);
      if (k < 5) begin
        tick();
        gap = 1;
        while (bus_a.req_ready == 3'b000 && gap < 20) begin
          tick();
          gap++;
        end
        check($sformatf("t3_gap%0d", k), gap, 5);
      end
    end
    tick();
    bus_a.req_valid = 3'b000;
    repeat (3) tick();
    check("t3_last_rsp", bus_a.rsp_valid, exp_grant);
    tick();

    // Decode error on the COMP=3 instance
    bus_b.req_valid         = 3'b001;
    bus_b.req_write         = 3'b000;
    bus_b.req_addr[0 +: 32] = 32'hC000_0000;
    #1;
    check("t4_req_ready", bus_b.req_ready, 3'b001);
    tick();  // T+1
    bus_b.req_valid = 3'b000;
    check("t4_no_mtrans", bus_b.MTRANS, 1'b0);
    check("t4_msel", bus_b.MSELx, 3'b000);
    check("t4_rsp_valid", bus_b.rsp_valid, 3'b001);
    check("t4_rsp_err", bus_b.rsp_err, 1'b1);
    check("t4_rsp_rdata", bus_b.rsp_rdata, 32'h0);
    tick();  // T+2
    check("t4_rsp_pulse", bus_b.rsp_valid, 3'b000);
    check("t4_err_clear", bus_b.rsp_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
